// File: rtl/oled_pkg.sv
// oled_pkg: shared sequencer states and default panel timing for the SSD1306 OLED interface.
// Revision: 1.0
`default_nettype none

package oled_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_VDD_WAIT  = 3'd1,
    ST_RES_LOW   = 3'd2,
    ST_RES_WAIT  = 3'd3,
    ST_VBAT_WAIT = 3'd4,
    ST_READY     = 3'd5,
    ST_DRAIN     = 3'd6,
    ST_VBAT_OFF  = 3'd7
  } seq_state_t;

  localparam int T_VDD_1MS    = 100000;
  localparam int T_RES_3US    = 300;
  localparam int T_VBAT_100MS = 10000000;

  localparam logic SCLK_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/oled_spi_shift.sv
// oled_spi_shift: MSB-first byte shifter with SCLK half-period divider; SDIN changes on SCLK fall.
// Revision: 1.0
`default_nettype none

module oled_spi_shift
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       dc,
  output logic       idle,
  output logic       SDIN,
  output logic       SCLK,
  output logic       DC
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic           active;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic [DW-1:0]  div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      div_cnt <= '0;
      SDIN    <= 1'b0;
      SCLK    <= SCLK_IDLE;
      DC      <= 1'b0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        shreg   <= data;
        bit_cnt <= 3'd7;
        div_cnt <= DIV_LOAD;
        SDIN    <= data[7];
        SCLK    <= 1'b0;
        DC      <= dc;
      end
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - DW'(1);
    end else if (!SCLK) begin
      SCLK    <= 1'b1;
      div_cnt <= DIV_LOAD;
    end else if (bit_cnt == 3'd0) begin
      // Last high phase done: SCLK is left at its idle level.
      active <= 1'b0;
    end else begin
      SCLK    <= 1'b0;
      SDIN    <= shreg[6];
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt - 3'd1;
      div_cnt <= DIV_LOAD;
    end
  end

  assign idle = !active;

endmodule

`default_nettype wire

// File: rtl/oled_spi_seq.sv
// oled_spi_seq: SSD1306 power sequencer (VDD/RES/VBAT) and byte-stream front end of the SPI shifter.
// Revision: 1.0
`default_nettype none

module oled_spi_seq
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int T_VDD   = T_VDD_1MS,
  parameter int T_RES   = T_RES_3US,
  parameter int T_VBAT  = T_VBAT_100MS
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESET,
  input  logic       en,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       pwr_good,
  output logic       busy,
  output logic       SDIN,
  output logic       SCLK,
  output logic       DC,
  output logic       RES,
  output logic       VBAT,
  output logic       VDD
);

  localparam int T_MAX0 = (T_VDD > T_RES) ? T_VDD : T_RES;
  localparam int T_MAX  = (T_MAX0 > T_VBAT) ? T_MAX0 : T_VBAT;
  localparam int TW     = $clog2(T_MAX) + 1;

  seq_state_t    state, state_next;
  logic [TW-1:0] timer, timer_load;
  logic          shift_idle;
  logic          start;
  logic          timer_done;

  assign timer_done = (timer == '0);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state <= ST_OFF;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        timer <= timer_load;
      end else if (!timer_done) begin
        timer <= timer - TW'(1);
      end
    end
  end

  // Loading N-1 on entry makes each timed state last exactly N cycles.
  always_comb begin
    timer_load = '0;
    case (state_next)
      ST_VDD_WAIT:  timer_load = TW'(T_VDD - 1);
      ST_RES_LOW:   timer_load = TW'(T_RES - 1);
      ST_RES_WAIT:  timer_load = TW'(T_RES - 1);
      ST_VBAT_WAIT: timer_load = TW'(T_VBAT - 1);
      ST_VBAT_OFF:  timer_load = TW'(T_VBAT - 1);
      default:      timer_load = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:       if (en) state_next = ST_VDD_WAIT;
      ST_VDD_WAIT:  if (!en) state_next = ST_VBAT_OFF;
                    else if (timer_done) state_next = ST_RES_LOW;
      ST_RES_LOW:   if (!en) state_next = ST_VBAT_OFF;
                    else if (timer_done) state_next = ST_RES_WAIT;
      ST_RES_WAIT:  if (!en) state_next = ST_VBAT_OFF;
                    else if (timer_done) state_next = ST_VBAT_WAIT;
      ST_VBAT_WAIT: if (!en) state_next = ST_VBAT_OFF;
                    else if (timer_done) state_next = ST_READY;
      ST_READY:     if (!en) state_next = ST_DRAIN;
      ST_DRAIN:     if (shift_idle) state_next = ST_VBAT_OFF;
      ST_VBAT_OFF:  if (timer_done) state_next = ST_OFF;
      default:      state_next = ST_OFF;
    endcase
  end

  assign VDD      = (state == ST_OFF);
  assign RES      = (state != ST_RES_LOW);
  assign VBAT     = !((state == ST_VBAT_WAIT) || (state == ST_READY) || (state == ST_DRAIN));
  assign pwr_good = (state == ST_READY) || (state == ST_DRAIN);
  assign tx_ready = (state == ST_READY) && shift_idle && en;
  assign busy     = !shift_idle || !((state == ST_OFF) || (state == ST_READY));
  assign start    = tx_valid && tx_ready;

  oled_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .start (start),
    .data  (tx_data),
    .dc    (tx_dc),
    .idle  (shift_idle),
    .SDIN  (SDIN),
    .SCLK  (SCLK),
    .DC    (DC)
  );

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_seq.sv
// tb_oled_spi_seq: scoreboarded bench for the OLED power sequencer and SPI byte shifter.
// Revision: 1.0
`default_nettype none

module tb_oled_spi_seq;

  localparam int CLK_DIV = 2;
  localparam int T_VDD   = 10;
  localparam int T_RES   = 3;
  localparam int T_VBAT  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       pwr_good;
  logic       busy;
  logic       SDIN, SCLK, DC, RES, VBAT, VDD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_spi_seq #(
    .CLK_DIV (CLK_DIV),
    .T_VDD   (T_VDD),
    .T_RES   (T_RES),
    .T_VBAT  (T_VBAT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .en           (en),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_dc        (tx_dc),
    .pwr_good     (pwr_good),
    .busy         (busy),
    .SDIN         (SDIN),
    .SCLK         (SCLK),
    .DC           (DC),
    .RES          (RES),
    .VBAT         (VBAT),
    .VDD          (VDD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries are {dc, sdin} expected at each SCLK rising edge.
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  int         edges = 0;
  logic       prev_sclk = 1'b1;

  task automatic push_byte(input logic [7:0] d, input logic dcv);
    for (int i = 7; i >= 0; i--) exp_q.push_back({dcv, d[i]});
  endtask

  always @(posedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
    end else if (!prev_sclk && SCLK) begin
      edges++;
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sdin_at_rise", SDIN, mon_e[0]);
        check("dc_at_rise", DC, mon_e[1]);
      end
    end
    prev_sclk = SCLK;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, output int waited);
    waited = 0;
    while (!tx_ready && waited < 200) begin
      step(1);
      waited++;
    end
    check(tag, tx_ready, 1);
  endtask

  // Called from OFF with en=0; returns at the first READY cycle.
  task automatic powerup(input logic hold_valid);
    int e_pu;
    tx_valid = hold_valid;
    tx_data  = 8'hA5;
    tx_dc    = 1'b0;
    e_pu     = edges;
    check("vdd_off_c0", VDD, 1);
    en = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      step(1);
      check("pu_vdd", VDD, 0);
      check("pu_res", RES, !(c >= 11 && c <= 13));
      check("pu_vbat", VBAT, (c < 17));
      check("pu_pwr_good", pwr_good, (c >= 37));
      if (c < 37) begin
        check("pu_ready_early", tx_ready, 0);
        check("pu_sclk_idle", SCLK, 1);
      end
    end
    check("pu_no_edges", edges - e_pu, 0);
    check("pu_ready_c37", tx_ready, 1);
  endtask

  initial begin
    int e0, w, rel;

    rst = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_dc = 1'b0;
    step(2);
    check("rst_sdin", SDIN, 0);
    check("rst_sclk", SCLK, 1);
    check("rst_dc", DC, 0);
    check("rst_res", RES, 1);
    check("rst_vbat", VBAT, 1);
    check("rst_vdd", VDD, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_pwr_good", pwr_good, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);
    check("off_vdd", VDD, 1);
    check("off_busy", busy, 0);

    // Power-up with tx_valid held; the first byte goes in the first READY cycle.
    powerup(1'b1);
    push_byte(8'hA5, 1'b0);
    e0 = edges;
    for (int c = 1; c <= 32; c++) begin
      step(1);
      if (c == 1) tx_valid = 1'b0;
      check("single_ready_low", tx_ready, 0);
      check("single_dc", DC, 0);
    end
    step(1);
    check("single_ready_c33", tx_ready, 1);
    check("single_edges", edges - e0, 8);
    check("single_sb_empty", exp_q.size(), 0);

    // Back-to-back bytes with tx_valid held.
    tx_valid = 1'b1; tx_data = 8'h81; tx_dc = 1'b0;
    wait_ready("b2b_rdy1", w);
    push_byte(8'h81, 1'b0);
    e0 = edges;
    step(1);
    tx_data = 8'hFF; tx_dc = 1'b1;
    wait_ready("b2b_rdy2", w);
    check("b2b_interval", w + 1, 33);
    check("b2b_dc_before", DC, 0);
    push_byte(8'hFF, 1'b1);
    step(1);
    tx_valid = 1'b0;
    check("b2b_dc_toggle", DC, 1);
    check("b2b_sclk_fall", SCLK, 0);
    wait_ready("b2b_rdy3", w);
    check("b2b_edges", edges - e0, 16);

    // Drop en after the 3rd bit: byte completes, then the rails go down.
    tx_valid = 1'b1; tx_data = 8'h3C; tx_dc = 1'b1;
    push_byte(8'h3C, 1'b1);
    e0 = edges;
    step(1);
    rel = 1;
    tx_valid = 1'b0;
    while ((edges - e0) < 3 && rel < 100) begin
      step(1);
      rel++;
    end
    check("drop_third_edge", edges - e0, 3);
    en = 1'b0;
    #1;
    check("drop_ready_now", tx_ready, 0);
    while (!VBAT && rel < 200) begin
      step(1);
      rel++;
      if (!VBAT) check("drain_pwr_good", pwr_good, 1);
    end
    check("drop_vbat_cycle", rel, 34);
    check("drop_pwr_good", pwr_good, 0);
    check("drop_edges", edges - e0, 8);
    check("drop_vdd_on", VDD, 0);
    for (int k = 1; k <= T_VBAT; k++) begin
      step(1);
      check("drop_vdd", VDD, (k == T_VBAT));
      check("drop_ready", tx_ready, 0);
    end
    check("drop_busy_off", busy, 0);

    // Abort during RES_LOW; en=1 during VBAT_OFF waits for OFF.
    en = 1'b1;
    step(12);
    check("abort_res_low", RES, 0);
    en = 1'b0;
    step(1);
    check("abort_res", RES, 1);
    check("abort_vbat", VBAT, 1);
    check("abort_vdd", VDD, 0);
    check("abort_busy", busy, 1);
    en = 1'b1;
    for (int k = 1; k <= T_VBAT + 1; k++) begin
      step(1);
      check("abort_vdd_wait", VDD, (k == T_VBAT));
    end
    w = 0;
    while (!pwr_good && w < 100) begin
      step(1);
      w++;
    end
    check("repower_pg", pwr_good, 1);
    check("repower_cycles", w, 36);

    // Async reset mid-byte, between clock edges.
    tx_valid = 1'b1; tx_data = 8'hC3; tx_dc = 1'b0;
    wait_ready("rst_rdy", w);
    push_byte(8'hC3, 1'b0);
    e0 = edges;
    step(1);
    tx_valid = 1'b0;
    w = 0;
    while (((edges - e0) < 2 || SCLK) && w < 100) begin
      step(1);
      w++;
    end
    check("rst_mid_sclk_low", SCLK, 0);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("arst_sclk", SCLK, 1);
    check("arst_vdd", VDD, 1);
    check("arst_vbat", VBAT, 1);
    check("arst_res", RES, 1);
    check("arst_tx_ready", tx_ready, 0);
    check("arst_pwr_good", pwr_good, 0);
    check("arst_busy", busy, 0);
    check("arst_sdin", SDIN, 0);
    step(2);
    rst = 1'b0;
    step(1);
    powerup(1'b0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
